// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run controller for the out-of-order CPU.
// Holds the core in reset for RST_CYCLES after rstn releases, then counts run
// cycles and committed instructions until a halt, a commit-stall hang or the
// cycle budget ends the run.
// Optional per-lane commit totals are enabled with CPU_RUN_MONITOR_LANE_CNT_EN.
module cpu_run_monitor #(
    parameter int RST_CYCLES   = 4,
    parameter int MAX_CYCLES   = 300,
    parameter int HANG_CYCLES  = 64,
    parameter int COMMIT_WIDTH = 2,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [COMMIT_WIDTH-1:0] commit_valid,
    input  logic                    halt_req,
    output logic                    core_rstn,
    output logic [1:0]              state,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        commit_count,
    output logic                    done,
    output logic                    halted,
    output logic                    hang,
    output logic                    timeout
`ifdef CPU_RUN_MONITOR_LANE_CNT_EN
    ,
    output logic [COMMIT_WIDTH*CNT_W-1:0] lane_count
`endif
);

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_RUN   = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] rst_cnt;
    logic [CNT_W-1:0] rst_cnt_d;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_d;
    logic [CNT_W-1:0] cycle_d;
    logic [CNT_W-1:0] commit_d;
    logic [CNT_W-1:0] pop;
    logic [CNT_W:0]   commit_sum;
    logic             core_rstn_d;
    logic             done_d;
    logic             halted_d;
    logic             hang_d;
    logic             timeout_d;

    assign state = state_q;

    // Count how many commit lanes retired an instruction this cycle.
    always_comb begin
        pop = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            pop = pop + CNT_W'(commit_valid[i]);
        end
    end

    // Next-state logic: reset hold countdown, run accounting and termination.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt;
        idle_cnt_d  = idle_cnt;
        cycle_d     = cycle_count;
        commit_d    = commit_count;
        core_rstn_d = core_rstn;
        done_d      = done;
        halted_d    = halted;
        hang_d      = hang;
        timeout_d   = timeout;
        commit_sum  = {1'b0, commit_count} + {1'b0, pop};
        case (state_q)
            ST_RESET: begin
                rst_cnt_d = rst_cnt + CNT_W'(1);
                if (rst_cnt_d == CNT_W'(RST_CYCLES)) begin
                    state_d     = ST_RUN;
                    core_rstn_d = 1'b1;
                end
            end
            ST_RUN: begin
                cycle_d    = cycle_count + CNT_W'(1);
                commit_d   = commit_sum[CNT_W] ? '1 : commit_sum[CNT_W-1:0];
                idle_cnt_d = (|commit_valid) ? '0 : idle_cnt + CNT_W'(1);
                if (halt_req) begin
                    halted_d = 1'b1;
                end else if (idle_cnt_d == CNT_W'(HANG_CYCLES)) begin
                    hang_d = 1'b1;
                end else if (cycle_d == CNT_W'(MAX_CYCLES)) begin
                    timeout_d = 1'b1;
                end
                if (halted_d || hang_d || timeout_d) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Register every output and internal counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_RESET;
            rst_cnt      <= '0;
            idle_cnt     <= '0;
            cycle_count  <= '0;
            commit_count <= '0;
            core_rstn    <= 1'b0;
            done         <= 1'b0;
            halted       <= 1'b0;
            hang         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt      <= rst_cnt_d;
            idle_cnt     <= idle_cnt_d;
            cycle_count  <= cycle_d;
            commit_count <= commit_d;
            core_rstn    <= core_rstn_d;
            done         <= done_d;
            halted       <= halted_d;
            hang         <= hang_d;
            timeout      <= timeout_d;
        end
    end

`ifdef CPU_RUN_MONITOR_LANE_CNT_EN
    logic [COMMIT_WIDTH*CNT_W-1:0] lane_d;

    // Per-lane saturating commit totals, advancing only while running.
    always_comb begin
        lane_d = lane_count;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (commit_valid[i] && (lane_count[i*CNT_W +: CNT_W] != '1)) begin
                    lane_d[i*CNT_W +: CNT_W] = lane_count[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    // Register the per-lane totals.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lane_count <= '0;
        end else begin
            lane_count <= lane_d;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: table vectors, directed corner sequences and a
// randomized run against a behavioural model of the run monitor.
module tb_cpu_run_monitor;

    localparam int RST_CYCLES   = 4;
    localparam int MAX_CYCLES   = 20;
    localparam int HANG_CYCLES  = 8;
    localparam int COMMIT_WIDTH = 2;
    localparam int CNT_W        = 5;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic [COMMIT_WIDTH-1:0] commit_valid = '0;
    logic                    halt_req = 1'b0;
    logic                    core_rstn;
    logic [1:0]              state;
    logic [CNT_W-1:0]        cycle_count;
    logic [CNT_W-1:0]        commit_count;
    logic                    done;
    logic                    halted;
    logic                    hang;
    logic                    timeout;
`ifdef CPU_RUN_MONITOR_LANE_CNT_EN
    logic [COMMIT_WIDTH*CNT_W-1:0] lane_count;
`endif

    int tests    = 0;
    int failures = 0;

    // Behavioural model: phase 0 reset hold, 1 running, 2 finished.
    // Reason 0 none, 1 halted, 2 hang, 3 timeout.
    int m_phase  = 0;
    int m_rst    = 0;
    int m_cyc    = 0;
    int m_com    = 0;
    int m_idle   = 0;
    int m_reason = 0;
    int m_lane [COMMIT_WIDTH];

    typedef struct {
        logic       rstn;
        logic [1:0] cv;
        logic       halt;
        int         exp_core;
        int         exp_state;
        int         exp_cyc;
        int         exp_com;
        int         exp_done;
        int         exp_reason;
    } vec_t;

    vec_t vecs [13];

    cpu_run_monitor #(
        .RST_CYCLES  (RST_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .HANG_CYCLES (HANG_CYCLES),
        .COMMIT_WIDTH(COMMIT_WIDTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .commit_valid(commit_valid),
        .halt_req    (halt_req),
        .core_rstn   (core_rstn),
        .state       (state),
        .cycle_count (cycle_count),
        .commit_count(commit_count),
        .done        (done),
        .halted      (halted),
        .hang        (hang),
        .timeout     (timeout)
`ifdef CPU_RUN_MONITOR_LANE_CNT_EN
        ,
        .lane_count  (lane_count)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic void modelEdge(input logic r, input logic [1:0] cv, input logic h);
        int pc;
        if (!r) begin
            m_phase = 0; m_rst = 0; m_cyc = 0; m_com = 0; m_idle = 0; m_reason = 0;
            for (int i = 0; i < COMMIT_WIDTH; i++) m_lane[i] = 0;
        end else if (m_phase == 0) begin
            m_rst++;
            if (m_rst == RST_CYCLES) m_phase = 1;
        end else if (m_phase == 1) begin
            pc = $countones(cv);
            m_cyc++;
            m_com = (m_com + pc > CNT_MAX) ? CNT_MAX : m_com + pc;
            for (int i = 0; i < COMMIT_WIDTH; i++)
                if (cv[i] && m_lane[i] < CNT_MAX) m_lane[i]++;
            m_idle = (pc != 0) ? 0 : m_idle + 1;
            if (h) m_reason = 1;
            else if (m_idle == HANG_CYCLES) m_reason = 2;
            else if (m_cyc == MAX_CYCLES) m_reason = 3;
            if (m_reason != 0) m_phase = 2;
        end
    endfunction

    task automatic checkValue(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] cv, input logic h);
        rstn         = r;
        commit_valid = cv;
        halt_req     = h;
        @(posedge clk);
        modelEdge(r, cv, h);
        #1;
    endtask

    task automatic checkOutput();
        checkValue("core_rstn", int'(core_rstn), int'(m_phase != 0));
        checkValue("state", int'(state), m_phase);
        checkValue("cycle_count", int'(cycle_count), m_cyc);
        checkValue("commit_count", int'(commit_count), m_com);
        checkValue("done", int'(done), int'(m_phase == 2));
        checkValue("halted", int'(halted), int'(m_reason == 1));
        checkValue("hang", int'(hang), int'(m_reason == 2));
        checkValue("timeout", int'(timeout), int'(m_reason == 3));
`ifdef CPU_RUN_MONITOR_LANE_CNT_EN
        for (int i = 0; i < COMMIT_WIDTH; i++)
            checkValue($sformatf("lane%0d", i), int'(lane_count[i*CNT_W +: CNT_W]), m_lane[i]);
`endif
    endtask

    task automatic runStep(input logic r, input logic [1:0] cv, input logic h);
        applyStimulus(r, cv, h);
        checkOutput();
    endtask

    task automatic resetAndRelease();
        runStep(1'b0, 2'b00, 1'b0);
        for (int i = 0; i < RST_CYCLES; i++) runStep(1'b1, 2'b00, 1'b0);
    endtask

    initial begin
        int quiet;
        logic r;
        logic [1:0] cv;
        logic h;

        // Reset hold with inputs ignored, commit counting, then halt and freeze.
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b0, 2'd3, 1'b1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1'b1, 2'd3, 1'b1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1'b1, 2'd3, 1'b0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1'b1, 2'd0, 1'b1, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1'b1, 2'd3, 1'b1, 1, 1, 0, 0, 0, 0};
        vecs[6]  = '{1'b1, 2'd3, 1'b0, 1, 1, 1, 2, 0, 0};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 1, 1, 2, 4, 0, 0};
        vecs[8]  = '{1'b1, 2'd3, 1'b0, 1, 1, 3, 6, 0, 0};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 1, 1, 4, 7, 0, 0};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 1, 1, 5, 8, 0, 0};
        vecs[11] = '{1'b1, 2'd0, 1'b1, 1, 2, 6, 8, 1, 1};
        vecs[12] = '{1'b1, 2'd3, 1'b0, 1, 2, 6, 8, 1, 1};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].cv, vecs[i].halt);
            checkValue($sformatf("vec%0d core_rstn", i), int'(core_rstn), vecs[i].exp_core);
            checkValue($sformatf("vec%0d state", i), int'(state), vecs[i].exp_state);
            checkValue($sformatf("vec%0d cycle", i), int'(cycle_count), vecs[i].exp_cyc);
            checkValue($sformatf("vec%0d commit", i), int'(commit_count), vecs[i].exp_com);
            checkValue($sformatf("vec%0d done", i), int'(done), vecs[i].exp_done);
            checkValue($sformatf("vec%0d halted", i), int'(halted), int'(vecs[i].exp_reason == 1));
            checkValue($sformatf("vec%0d hang", i), int'(hang), int'(vecs[i].exp_reason == 2));
            checkValue($sformatf("vec%0d timeout", i), int'(timeout), int'(vecs[i].exp_reason == 3));
`ifdef CPU_RUN_MONITOR_LANE_CNT_EN
            checkOutput();
`endif
        end

        // Halt on the tenth run edge, then hold and confirm everything is frozen.
        resetAndRelease();
        for (int i = 0; i < 9; i++) runStep(1'b1, 2'b01, 1'b0);
        runStep(1'b1, 2'b10, 1'b1);
        checkValue("halt cycle", int'(cycle_count), 10);
        checkValue("halt flag", int'(halted), 1);
        for (int i = 0; i < 5; i++) begin
            runStep(1'b1, 2'b11, 1'b1);
            checkValue("halt frozen cycle", int'(cycle_count), 10);
            checkValue("halt frozen commit", int'(commit_count), 10);
        end

        // Hang with no commits at all.
        resetAndRelease();
        for (int i = 0; i < HANG_CYCLES; i++) runStep(1'b1, 2'b00, 1'b0);
        checkValue("hang flag", int'(hang), 1);
        checkValue("hang done", int'(done), 1);
        checkValue("hang cycle", int'(cycle_count), 8);
        checkValue("hang commit", int'(commit_count), 0);

        // Cycle budget expiry with one commit per cycle.
        resetAndRelease();
        for (int i = 0; i < MAX_CYCLES; i++) runStep(1'b1, 2'b01, 1'b0);
        checkValue("timeout flag", int'(timeout), 1);
        checkValue("timeout cycle", int'(cycle_count), 20);
        checkValue("timeout commit", int'(commit_count), 20);

        // Halt coinciding with the budget wins.
        resetAndRelease();
        for (int i = 0; i < MAX_CYCLES - 1; i++) runStep(1'b1, 2'b01, 1'b0);
        runStep(1'b1, 2'b01, 1'b1);
        checkValue("prio halted", int'(halted), 1);
        checkValue("prio timeout", int'(timeout), 0);

        // Hang coinciding with the budget wins over timeout.
        resetAndRelease();
        for (int i = 0; i < 12; i++) runStep(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < HANG_CYCLES; i++) runStep(1'b1, 2'b00, 1'b0);
        checkValue("prio2 hang", int'(hang), 1);
        checkValue("prio2 timeout", int'(timeout), 0);
        checkValue("prio2 cycle", int'(cycle_count), 20);

        // Commit counter saturates at all-ones.
        resetAndRelease();
        for (int i = 0; i < 16; i++) runStep(1'b1, 2'b11, 1'b0);
        checkValue("sat commit", int'(commit_count), CNT_MAX);
        runStep(1'b1, 2'b11, 1'b0);
        checkValue("sat commit hold", int'(commit_count), CNT_MAX);

        // Reset pulse mid-run restarts the whole reset hold.
        resetAndRelease();
        for (int i = 0; i < 6; i++) runStep(1'b1, 2'b01, 1'b0);
        runStep(1'b0, 2'b11, 1'b1);
        checkValue("midrst core_rstn", int'(core_rstn), 0);
        checkValue("midrst state", int'(state), 0);
        checkValue("midrst cycle", int'(cycle_count), 0);
        checkValue("midrst commit", int'(commit_count), 0);
        for (int i = 0; i < RST_CYCLES - 1; i++) begin
            runStep(1'b1, 2'b11, 1'b0);
            checkValue("midrst hold", int'(core_rstn), 0);
        end
        runStep(1'b1, 2'b11, 1'b0);
        checkValue("midrst release", int'(core_rstn), 1);
        checkValue("midrst run", int'(state), 1);

        // Randomized traffic with idle bursts, sporadic halts and resets.
        quiet = 0;
        for (int n = 0; n < 600; n++) begin
            r = 1'b1;
            if (m_phase == 2 && $urandom_range(0, 3) == 0) r = 1'b0;
            else if ($urandom_range(0, 59) == 0) r = 1'b0;
            if (quiet > 0) begin
                cv = 2'b00;
                quiet--;
            end else begin
                cv = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 24) == 0) quiet = int'($urandom_range(5, 12));
            end
            h = ($urandom_range(0, 39) == 0);
            runStep(r, cv, h);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Parametrised run controller for the out-of-order CPU that replaces the fixed reset pulse and fixed stop time used in simulation with a synthesizable block. It holds the core in reset for a configurable number of cycles after the system reset releases, then counts run cycles and committed instructions across a configurable commit width. It ends the run on a program halt, a commit-stall hang, or a cycle budget, and reports which one occurred. It sits between the top-level clock/reset and the `CPU` instance, and reads the ROB commit lanes.

## Interface
Parameters:
- RST_CYCLES, 4: cycles `core_rstn` stays low after `rstn` is sampled high (≥1)
- MAX_CYCLES, 300: run-cycle budget before timeout (≥1)
- HANG_CYCLES, 64: consecutive commit-free run cycles that count as a hang (≥1)
- COMMIT_WIDTH, 2: number of commit lanes (≥1)
- CNT_W, 32: width of all counters

Ports:
- clk  in  1  single clock; all logic updates on the rising edge
- rstn  in  1  reset, synchronous and active-low
- commit_valid  in  COMMIT_WIDTH  one bit per ROB commit lane
- halt_req  in  1  program-end request from the core (ecall/halt)
- core_rstn  out  1  registered active-low reset to the CPU
- state  out  2  00 RESET, 01 RUN, 10 DONE
- cycle_count  out  CNT_W  run cycles elapsed
- commit_count  out  CNT_W  instructions committed
- done  out  1  terminal state reached
- halted, hang, timeout  out  1 each  reason for termination; one-hot, and set only together with `done`
- lane_count  out  COMMIT_WIDTH*CNT_W  per-lane commit totals, lane i at [i*CNT_W +: CNT_W]; present only with the macro (see Configuration)

## Operation
- **Reset.** `rstn`=0 at an edge puts the block in state RESET. This applies from any state.
  - Every counter, `rst_cnt`, `idle_cnt`, `done` and every reason flag goes to 0.
  - `core_rstn` goes to 0.
- **RESET.** Each edge with `rstn`=1 increments `rst_cnt`.
  - On the edge where `rst_cnt` reaches RST_CYCLES, the state becomes RUN and `core_rstn` goes to 1.
  - `commit_valid` and `halt_req` are ignored in this state.
- **RUN, on every edge:**
  - `cycle_count` increments by 1.
  - `commit_count` increments by popcount(`commit_valid`) and saturates at all-ones.
  - `idle_cnt` clears when any commit bit is set, and increments otherwise.
- **Terminal conditions in RUN**, all evaluated on post-update values at the same edge:
  - `halt_req`=1 → halted
  - `idle_cnt` equals HANG_CYCLES → hang
  - `cycle_count` equals MAX_CYCLES → timeout
- **Terminal transition.** When any terminal condition holds, the state becomes DONE, `done` goes to 1, and exactly one reason flag is set.
  - Priority when several hold: halted > hang > timeout.
  - Commits and the cycle increment on that edge are still counted.
- **DONE.** All outputs are frozen and `core_rstn` stays 1. The only exit is `rstn`=0.
- **Arithmetic.** The popcount result is zero-extended to CNT_W before the add. `cycle_count` cannot exceed MAX_CYCLES.

## Timing
- **Reset values:** `core_rstn`=0, `state`=00, counters 0, `done`/`halted`/`hang`/`timeout`=0, `lane_count`=0.
- **`core_rstn` release:** rises on the RST_CYCLES-th edge after the first edge at which `rstn`=1 is sampled.
- **Run accounting:** the first RUN edge is the one after that edge, and it yields `cycle_count`=1.
- **Latency:** every input takes effect at the next edge; all outputs are registered.
- **Terminal edge:** `done` and its reason flag rise on the same edge as the final counter update.
- **`rstn` deasserted for one cycle mid-RUN:**
  - Counters read 0 on the next edge.
  - The RESET sequence restarts from `rst_cnt`=0.

## Configuration
- **`CPU_RUN_MONITOR_LANE_CNT_EN` defined:**
  - The `lane_count` port exists.
  - Lane i increments by 1 on each RUN edge with `commit_valid[i]`=1.
  - Each lane saturates at all-ones, clears on reset, and freezes in DONE.
- **Macro not defined:** the port and its counters are absent. All other behaviour is identical.

## Test plan
1. **Reset sequence.** `rstn`=0 for 2 edges, then 1, with RST_CYCLES=4 → `core_rstn`=0 through 3 edges, and 1 with `state`=01 at the 4th; counters are 0.
2. **Commit counting.** COMMIT_WIDTH=2; drive `commit_valid`=11 for 3 RUN cycles, then 01 for 2 → `commit_count`=8, `cycle_count`=5, `idle_cnt`=0. With the macro: lane0=5, lane1=3.
3. **Halt.** `halt_req`=1 on RUN edge 10 → `done`=1, `halted`=1, `cycle_count`=10. Held 5 more edges, all outputs are unchanged.
4. **Hang.** HANG_CYCLES=8, `commit_valid`=0 throughout → `hang`=1 and `done`=1 at RUN edge 8, with `cycle_count`=8 and `commit_count`=0.
5. **Timeout and priority.**
   - MAX_CYCLES=20, commit every cycle → `timeout`=1 with `cycle_count`=20 and `commit_count`=20.
   - Repeat with `halt_req`=1 on edge 20 → only `halted`=1.
6. **Reset mid-run.** `rstn`=0 for one edge at RUN cycle 7 → `core_rstn`=0, all counters 0 and `state`=00 on that edge; the full 4-edge reset sequence then repeats.
